// File: rtl/scaler_pkg.sv
// ---------------------------------------------------------------------------
// scaler_pkg
// Shared definitions for the RGB scaler ratio path:
//   FRAC_W_DEFAULT : default number of ratio fraction bits
//   RATIO_ONE      : 1.0 in the default fixed-point format
//   state_t        : ratio generator FSM states
//   num_width()    : width of the dividend (destination field + fraction)
// ---------------------------------------------------------------------------
package scaler_pkg;

    localparam int FRAC_W_DEFAULT = 16;
    localparam int RATIO_ONE      = 1 << FRAC_W_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DIV    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // The dividend is SRC << FRAC_W, and SRC fits in a dimension field.
    function automatic int num_width(input int dim_w, input int frac_w);
        return dim_w + frac_w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative restoring unsigned divider, one quotient bit per enabled step,
// MSB first. After NUM_W steps quotient = floor(num_in / den_in).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load num_in/den_in, clear remainder and quotient
//   step       : perform one divide iteration
//   num_in     : dividend (NUM_W bits)
//   den_in     : divisor  (DIM_W bits)
//   quotient   : running / final quotient (NUM_W bits)
//   den_zero   : divisor captured at start was zero
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int NUM_W = 28,
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [NUM_W-1:0] num_in,
    input  logic [DIM_W-1:0] den_in,
    output logic [NUM_W-1:0] quotient,
    output logic             den_zero
);

    logic [NUM_W-1:0] num_q, num_d;
    logic [DIM_W-1:0] den_q, den_d;
    logic [DIM_W:0]   rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic             zero_q, zero_d;

    logic [DIM_W:0]   rem_sh;
    logic             fits;

    // The remainder is always below the divisor, so its low DIM_W bits plus
    // the next dividend bit cover the shifted partial remainder.
    assign rem_sh = {rem_q[DIM_W-1:0], num_q[NUM_W-1]};
    assign fits   = (rem_sh >= {1'b0, den_q});

    always_comb begin
        num_d  = num_q;
        den_d  = den_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        zero_d = zero_q;
        if (start) begin
            num_d  = num_in;
            den_d  = den_in;
            rem_d  = '0;
            quo_d  = '0;
            zero_d = (den_in == '0);
        end else if (step) begin
            num_d = {num_q[NUM_W-2:0], 1'b0};
            rem_d = fits ? (rem_sh - {1'b0, den_q}) : rem_sh;
            quo_d = {quo_q[NUM_W-2:0], fits};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            zero_q <= zero_d;
        end
    end

    assign quotient = quo_q;
    assign den_zero = zero_q;

endmodule

// File: rtl/scale_ratio_gen.sv
// ---------------------------------------------------------------------------
// scale_ratio_gen
// Frame-synchronous scale-ratio generator. On each falling edge of
// per_img_vsync it latches the destination size, computes
// floor(SRC * 2^FRAC_W / DST) for both axes with two lockstep sequential
// dividers, and publishes ratios plus shadowed dimensions atomically.
// Ports:
//   clk_in2          : processing clock
//   rst_n            : asynchronous active-low reset
//   per_img_vsync    : frame sync, falling edge requests an update
//   c_dst_img_width  : requested destination width
//   c_dst_img_height : requested destination height
//   C_X_RATIO        : horizontal step, unsigned fixed point, FRAC_W fraction
//   C_Y_RATIO        : vertical step
//   C_DST_IMG_WIDTH  : destination width in effect
//   C_DST_IMG_HEIGHT : destination height in effect
//   ratio_valid      : one-cycle pulse when the published outputs update
//   busy             : computation in progress (LOAD, DIV, COMMIT)
//   dim_err          : last commit contained a zero dimension
// ---------------------------------------------------------------------------
module scale_ratio_gen
    import scaler_pkg::*;
#(
    parameter int SRC_W   = 640,
    parameter int SRC_H   = 480,
    parameter int DIM_W   = 12,
    parameter int FRAC_W  = FRAC_W_DEFAULT,
    parameter int RATIO_W = 17
) (
    input  logic               clk_in2,
    input  logic               rst_n,
    input  logic               per_img_vsync,
    input  logic [DIM_W-1:0]   c_dst_img_width,
    input  logic [DIM_W-1:0]   c_dst_img_height,
    output logic [RATIO_W-1:0] C_X_RATIO,
    output logic [RATIO_W-1:0] C_Y_RATIO,
    output logic [DIM_W-1:0]   C_DST_IMG_WIDTH,
    output logic [DIM_W-1:0]   C_DST_IMG_HEIGHT,
    output logic               ratio_valid,
    output logic               busy,
    output logic               dim_err
);

    localparam int NUM_W = num_width(DIM_W, FRAC_W);
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic [NUM_W-1:0]   NUM_X     = NUM_W'(SRC_W) << FRAC_W;
    localparam logic [NUM_W-1:0]   NUM_Y     = NUM_W'(SRC_H) << FRAC_W;
    localparam logic [RATIO_W-1:0] RATIO_1P0 = RATIO_W'(1) << FRAC_W;
    localparam logic [NUM_W-1:0]   SAT_N     = (NUM_W'(1) << RATIO_W) - NUM_W'(1);
    localparam logic [DIM_W-1:0]   SRC_W_D   = DIM_W'(SRC_W);
    localparam logic [DIM_W-1:0]   SRC_H_D   = DIM_W'(SRC_H);

    state_t              state_q, state_d;
    logic                vsync_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIM_W-1:0]    shad_w_q, shad_w_d, shad_h_q, shad_h_d;
    logic                pend_q, pend_d;
    logic [DIM_W-1:0]    pend_w_q, pend_w_d, pend_h_q, pend_h_d;
    logic [RATIO_W-1:0]  x_ratio_q, x_ratio_d, y_ratio_q, y_ratio_d;
    logic [DIM_W-1:0]    dst_w_q, dst_w_d, dst_h_q, dst_h_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                fall;
    logic                div_start, div_step;
    logic [NUM_W-1:0]    quo_x, quo_y;
    logic                zero_x, zero_y;

    function automatic logic [RATIO_W-1:0] saturate(input logic [NUM_W-1:0] q);
        return (q > SAT_N) ? SAT_N[RATIO_W-1:0] : q[RATIO_W-1:0];
    endfunction

    assign fall      = vsync_q & ~per_img_vsync;
    assign div_start = (state_q == ST_LOAD);
    assign div_step  = (state_q == ST_DIV);

    seq_divider #(.NUM_W(NUM_W), .DIM_W(DIM_W)) u_div_x (
        .clk      (clk_in2),
        .rst_n    (rst_n),
        .start    (div_start),
        .step     (div_step),
        .num_in   (NUM_X),
        .den_in   (shad_w_q),
        .quotient (quo_x),
        .den_zero (zero_x)
    );

    seq_divider #(.NUM_W(NUM_W), .DIM_W(DIM_W)) u_div_y (
        .clk      (clk_in2),
        .rst_n    (rst_n),
        .start    (div_start),
        .step     (div_step),
        .num_in   (NUM_Y),
        .den_in   (shad_h_q),
        .quotient (quo_y),
        .den_zero (zero_y)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shad_w_d  = shad_w_q;
        shad_h_d  = shad_h_q;
        pend_d    = pend_q;
        pend_w_d  = pend_w_q;
        pend_h_d  = pend_h_q;
        x_ratio_d = x_ratio_q;
        y_ratio_d = y_ratio_q;
        dst_w_d   = dst_w_q;
        dst_h_d   = dst_h_q;
        valid_d   = 1'b0;
        err_d     = err_q;

        // A frame sync arriving mid-computation is parked; last one wins.
        // In COMMIT it is consumed directly below instead.
        if (fall && (state_q == ST_LOAD || state_q == ST_DIV)) begin
            pend_d   = 1'b1;
            pend_w_d = c_dst_img_width;
            pend_h_d = c_dst_img_height;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    shad_w_d = c_dst_img_width;
                    shad_h_d = c_dst_img_height;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = CNT_W'(NUM_W);
                state_d = ST_DIV;
            end
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                x_ratio_d = zero_x ? RATIO_1P0 : saturate(quo_x);
                y_ratio_d = zero_y ? RATIO_1P0 : saturate(quo_y);
                dst_w_d   = zero_x ? SRC_W_D : shad_w_q;
                dst_h_d   = zero_y ? SRC_H_D : shad_h_q;
                err_d     = zero_x | zero_y;
                valid_d   = 1'b1;
                if (pend_q || fall) begin
                    // A sync landing in this very cycle is newer than the buffer.
                    shad_w_d = fall ? c_dst_img_width  : pend_w_q;
                    shad_h_d = fall ? c_dst_img_height : pend_h_q;
                    pend_d   = 1'b0;
                    state_d  = ST_LOAD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vsync_q   <= 1'b0;
            cnt_q     <= '0;
            shad_w_q  <= SRC_W_D;
            shad_h_q  <= SRC_H_D;
            pend_q    <= 1'b0;
            pend_w_q  <= '0;
            pend_h_q  <= '0;
            x_ratio_q <= RATIO_1P0;
            y_ratio_q <= RATIO_1P0;
            dst_w_q   <= SRC_W_D;
            dst_h_q   <= SRC_H_D;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= per_img_vsync;
            cnt_q     <= cnt_d;
            shad_w_q  <= shad_w_d;
            shad_h_q  <= shad_h_d;
            pend_q    <= pend_d;
            pend_w_q  <= pend_w_d;
            pend_h_q  <= pend_h_d;
            x_ratio_q <= x_ratio_d;
            y_ratio_q <= y_ratio_d;
            dst_w_q   <= dst_w_d;
            dst_h_q   <= dst_h_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign C_X_RATIO        = x_ratio_q;
    assign C_Y_RATIO        = y_ratio_q;
    assign C_DST_IMG_WIDTH  = dst_w_q;
    assign C_DST_IMG_HEIGHT = dst_h_q;
    assign ratio_valid      = valid_q;
    assign busy             = (state_q != ST_IDLE);
    assign dim_err          = err_q;

endmodule

// File: tb/tb_scale_ratio_gen.sv
// ---------------------------------------------------------------------------
// tb_scale_ratio_gen
// Directed bench for scale_ratio_gen at default parameters: a table of
// single-frame vectors, then hand-written back-to-back and reset sequences.
// ---------------------------------------------------------------------------
module tb_scale_ratio_gen;

    logic        clk_in2 = 1'b0;
    logic        rst_n   = 1'b0;
    logic        per_img_vsync = 1'b0;
    logic [11:0] c_dst_img_width  = 12'd0;
    logic [11:0] c_dst_img_height = 12'd0;
    logic [16:0] C_X_RATIO, C_Y_RATIO;
    logic [11:0] C_DST_IMG_WIDTH, C_DST_IMG_HEIGHT;
    logic        ratio_valid, busy, dim_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_in2 = ~clk_in2;

    scale_ratio_gen dut (
        .clk_in2          (clk_in2),
        .rst_n            (rst_n),
        .per_img_vsync    (per_img_vsync),
        .c_dst_img_width  (c_dst_img_width),
        .c_dst_img_height (c_dst_img_height),
        .C_X_RATIO        (C_X_RATIO),
        .C_Y_RATIO        (C_Y_RATIO),
        .C_DST_IMG_WIDTH  (C_DST_IMG_WIDTH),
        .C_DST_IMG_HEIGHT (C_DST_IMG_HEIGHT),
        .ratio_valid      (ratio_valid),
        .busy             (busy),
        .dim_err          (dim_err)
    );

    typedef struct {
        logic [11:0] w;
        logic [11:0] h;
        logic [16:0] ex;
        logic [16:0] ey;
        logic [11:0] ew;
        logic [11:0] eh;
        logic        eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [16:0] ex, input logic [16:0] ey,
                               input logic [11:0] ew, input logic [11:0] eh, input logic eerr);
        chk({tag, ".x_ratio"}, 32'(C_X_RATIO), 32'(ex));
        chk({tag, ".y_ratio"}, 32'(C_Y_RATIO), 32'(ey));
        chk({tag, ".dst_w"},   32'(C_DST_IMG_WIDTH), 32'(ew));
        chk({tag, ".dst_h"},   32'(C_DST_IMG_HEIGHT), 32'(eh));
        chk({tag, ".dim_err"}, 32'(dim_err), 32'(eerr));
    endtask

    // Requests a frame with a falling vsync edge; returns at the negedge just
    // after the posedge that samples the fall (E0).
    task automatic vsync_fall(input logic [11:0] w, input logic [11:0] h);
        per_img_vsync    = 1'b1;
        @(negedge clk_in2);
        per_img_vsync    = 1'b0;
        c_dst_img_width  = w;
        c_dst_img_height = h;
        @(negedge clk_in2);
    endtask

    task automatic run_vec(input int idx);
        logic [16:0] prev_x;
        string tag;
        tag = $sformatf("vec%0d", idx);
        prev_x = C_X_RATIO;
        vsync_fall(vecs[idx].w, vecs[idx].h);
        chk({tag, ".busy_after_e0"}, 32'(busy), 32'd1);
        // Now between E0 and E0+1; advance to between E0+29 and E0+30.
        repeat (29) @(negedge clk_in2);
        chk({tag, ".valid_early"}, 32'(ratio_valid), 32'd0);
        chk({tag, ".held_midframe"}, 32'(C_X_RATIO), 32'(prev_x));
        @(negedge clk_in2);
        chk({tag, ".valid_e0p30"}, 32'(ratio_valid), 32'd1);
        chk_outputs(tag, vecs[idx].ex, vecs[idx].ey, vecs[idx].ew, vecs[idx].eh, vecs[idx].eerr);
        $display("frame %0dx%0d -> x=%0d y=%0d w=%0d h=%0d err=%0d", vecs[idx].w, vecs[idx].h,
                 C_X_RATIO, C_Y_RATIO, C_DST_IMG_WIDTH, C_DST_IMG_HEIGHT, dim_err);
        @(negedge clk_in2);
        chk({tag, ".valid_single"}, 32'(ratio_valid), 32'd0);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{12'd1280, 12'd960,  17'd32768,  17'd32768, 12'd1280, 12'd960,  1'b0};
        vecs[1] = '{12'd1920, 12'd1080, 17'd21845,  17'd29127, 12'd1920, 12'd1080, 1'b0};
        vecs[2] = '{12'd160,  12'd480,  17'd131071, 17'd65536, 12'd160,  12'd480,  1'b0};
        vecs[3] = '{12'd0,    12'd960,  17'd65536,  17'd32768, 12'd640,  12'd960,  1'b1};
        vecs[4] = '{12'd1280, 12'd960,  17'd32768,  17'd32768, 12'd1280, 12'd960,  1'b0};
        vecs[5] = '{12'd640,  12'd0,    17'd65536,  17'd65536, 12'd640,  12'd480,  1'b1};
        vecs[6] = '{12'd4095, 12'd4095, 17'd10242,  17'd7681,  12'd4095, 12'd4095, 1'b0};
        vecs[7] = '{12'd1920, 12'd1080, 17'd21845,  17'd29127, 12'd1920, 12'd1080, 1'b0};

        // Reset state with no vsync activity.
        repeat (3) @(negedge clk_in2);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in2);
        chk_outputs("reset", 17'd65536, 17'd65536, 12'd640, 12'd480, 1'b0);
        chk("reset.valid", 32'(ratio_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
            repeat (2) @(negedge clk_in2);
        end

        // Back-to-back: second fall during DIV of a 1280x960 frame.
        vsync_fall(12'd1280, 12'd960);         // between E0 and E0+1
        repeat (9) @(negedge clk_in2);         // between E0+9 and E0+10
        per_img_vsync = 1'b1;
        @(negedge clk_in2);
        per_img_vsync    = 1'b0;               // fall sampled at E0+11 (DIV)
        c_dst_img_width  = 12'd1920;
        c_dst_img_height = 12'd1080;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk_in2);                // between E0+10+k and E0+11+k
            if (k == 12) begin
                c_dst_img_width  = 12'd100;    // changes after the fall must be ignored
                c_dst_img_height = 12'd100;
            end
            chk($sformatf("b2b.valid_k%0d", k), 32'(ratio_valid), (k == 20 || k == 50) ? 32'd1 : 32'd0);
            chk($sformatf("b2b.busy_k%0d", k), 32'(busy), (k < 50) ? 32'd1 : 32'd0);
            if (k == 20) begin
                chk_outputs("b2b.first", 17'd32768, 17'd32768, 12'd1280, 12'd960, 1'b0);
                $display("b2b first commit x=%0d y=%0d", C_X_RATIO, C_Y_RATIO);
            end
            if (k == 50) begin
                chk_outputs("b2b.second", 17'd21845, 17'd29127, 12'd1920, 12'd1080, 1'b0);
                $display("b2b second commit x=%0d y=%0d", C_X_RATIO, C_Y_RATIO);
            end
        end

        // Reset pulsed during DIV: outputs return at once, no commit follows.
        vsync_fall(12'd1280, 12'd960);
        repeat (10) @(negedge clk_in2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_rst", 17'd65536, 17'd65536, 12'd640, 12'd480, 1'b0);
        chk("async_rst.busy", 32'(busy), 32'd0);
        chk("async_rst.valid", 32'(ratio_valid), 32'd0);
        $display("async reset mid-DIV x=%0d y=%0d busy=%0d", C_X_RATIO, C_Y_RATIO, busy);
        @(negedge clk_in2);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in2);
            chk($sformatf("post_rst.valid_%0d", k), 32'(ratio_valid), 32'd0);
            chk($sformatf("post_rst.busy_%0d", k), 32'(busy), 32'd0);
        end
        chk_outputs("post_rst", 17'd65536, 17'd65536, 12'd640, 12'd480, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
